// File: rtl/bp_fe_pkg.sv
// Shared types for the FE memory port arbiter.
//   bp_fe_owner_e            : which requester owns an in-flight command
//   bp_fe_mem_owner_stage_s  : one stage of the ownership pipeline {v, owner}
package bp_fe_pkg;

    typedef enum logic {
        e_fe_owner_demand = 1'b0,
        e_fe_owner_aux    = 1'b1
    } bp_fe_owner_e;

    typedef struct packed {
        logic         v;
        bp_fe_owner_e owner;
    } bp_fe_mem_owner_stage_s;

    localparam int unsigned starve_cnt_width_gp = 8;

endpackage

// File: rtl/bp_fe_mem_starve_counter.sv
// Saturating starvation counter for the auxiliary requester.
// Ports:
//   clk_i       clock
//   reset_n_i   asynchronous active-low reset
//   clear_i     clear to zero (highest priority)
//   incr_i      increment, saturating at limit_p
//   at_limit_o  counter equals limit_p
module bp_fe_mem_starve_counter
    import bp_fe_pkg::*;
#(
    parameter int unsigned limit_p = 8
)
(
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic incr_i,
    output logic at_limit_o
);

    localparam logic [starve_cnt_width_gp-1:0] limit_lp = starve_cnt_width_gp'(limit_p);

    logic [starve_cnt_width_gp-1:0] cnt_r;
    logic [starve_cnt_width_gp-1:0] cnt_n;

    assign at_limit_o = (cnt_r == limit_lp);

    always_comb begin
        cnt_n = cnt_r;
        if (clear_i) begin
            cnt_n = '0;
        end else if (incr_i && !at_limit_o) begin
            cnt_n = cnt_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end

endmodule

// File: rtl/bp_fe_mem_arbiter.sv
// Arbitrates the single FE memory port between the demand requester (PC gen)
// and an auxiliary requester (prefetch / debug fetch). Ownership of each
// accepted command is tracked through the fixed 2-cycle I$ pipeline so poison
// is taken from the owner and each response is routed back to its owner.
// Ports:
//   clk_i, reset_n_i                      clock, async active-low reset
//   demand_cmd_*/demand_poison_i/resp_*   demand requester side
//   aux_cmd_*/aux_poison_i/aux_resp_*     auxiliary requester side
//   mem_cmd_*/mem_poison_o/mem_resp_*     memory side
//   protocol_err_o                        sticky: response with no live owner
module bp_fe_mem_arbiter
    import bp_fe_pkg::*;
#(
    parameter int unsigned mem_cmd_width_p  = 128,
    parameter int unsigned mem_resp_width_p = 72,
    parameter int unsigned starve_limit_p   = 8
)
(
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [mem_cmd_width_p-1:0]  demand_cmd_i,
    input  logic                        demand_cmd_v_i,
    output logic                        demand_cmd_yumi_o,
    input  logic                        demand_poison_i,
    output logic [mem_resp_width_p-1:0] demand_resp_o,
    output logic                        demand_resp_v_o,

    input  logic [mem_cmd_width_p-1:0]  aux_cmd_i,
    input  logic                        aux_cmd_v_i,
    output logic                        aux_cmd_yumi_o,
    input  logic                        aux_poison_i,
    output logic [mem_resp_width_p-1:0] aux_resp_o,
    output logic                        aux_resp_v_o,

    output logic [mem_cmd_width_p-1:0]  mem_cmd_o,
    output logic                        mem_cmd_v_o,
    input  logic                        mem_cmd_yumi_i,
    output logic                        mem_poison_o,
    input  logic [mem_resp_width_p-1:0] mem_resp_i,
    input  logic                        mem_resp_v_i,

    output logic                        protocol_err_o
);

    logic                   sel_aux;
    logic                   at_limit;
    bp_fe_mem_owner_stage_s s1_r, s1_n;
    bp_fe_mem_owner_stage_s s2_r, s2_n;
    logic                   poisoned_last_r;
    logic                   err_r;

    // Demand wins unless it is idle or aux has waited starve_limit_p grants.
    assign sel_aux = aux_cmd_v_i & (~demand_cmd_v_i | at_limit);

    assign mem_cmd_v_o       = demand_cmd_v_i | aux_cmd_v_i;
    assign mem_cmd_o         = sel_aux ? aux_cmd_i : demand_cmd_i;
    assign demand_cmd_yumi_o = mem_cmd_yumi_i & ~sel_aux;
    assign aux_cmd_yumi_o    = mem_cmd_yumi_i &  sel_aux;

    bp_fe_mem_starve_counter #(
        .limit_p (starve_limit_p)
    ) starve_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .clear_i    (~aux_cmd_v_i | aux_cmd_yumi_o),
        .incr_i     (aux_cmd_v_i & demand_cmd_yumi_o),
        .at_limit_o (at_limit)
    );

    assign mem_poison_o = s1_r.v &
        ((s1_r.owner == e_fe_owner_aux) ? aux_poison_i : demand_poison_i);

    always_comb begin
        s1_n       = '0;
        s1_n.v     = mem_cmd_yumi_i;
        s1_n.owner = sel_aux ? e_fe_owner_aux : e_fe_owner_demand;

        // A poisoned stage-1 entry advances as a bubble.
        s2_n       = '0;
        s2_n.v     = s1_r.v & ~mem_poison_o;
        s2_n.owner = s1_r.owner;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_r            <= '0;
            s2_r            <= '0;
            poisoned_last_r <= 1'b0;
            err_r           <= 1'b0;
        end else begin
            s1_r            <= s1_n;
            s2_r            <= s2_n;
            poisoned_last_r <= mem_poison_o;
            // The response slot of a poisoned entry is allowed to carry data.
            if (mem_resp_v_i && !s2_r.v && !poisoned_last_r) begin
                err_r <= 1'b1;
            end
        end
    end

    assign demand_resp_v_o = mem_resp_v_i & s2_r.v & (s2_r.owner == e_fe_owner_demand);
    assign aux_resp_v_o    = mem_resp_v_i & s2_r.v & (s2_r.owner == e_fe_owner_aux);
    assign demand_resp_o   = mem_resp_i;
    assign aux_resp_o      = mem_resp_i;
    assign protocol_err_o  = err_r;

endmodule
